// File: rtl/io_bridge.sv
// io_bridge
// Memory-mapped bus responder behind the CPU data bus. Each MEM-stage access
// is routed either to the data RAM or to the on-board peripherals: the LED
// register, synchronized switches/buttons, an 8-digit scanned 7-segment
// display and an optional free-running cycle timer.
// Reads are combinational from Bus_addr; writes commit on the next cpu_clk edge.
//
// Optional feature macro: IO_TIMER_EN (cycle timer at IO offset 0x020).
//
// Ports:
//   cpu_clk     in   1   system clock, rising edge
//   cpu_rst     in   1   synchronous active-high reset
//   Bus_addr    in  32   byte address from CPU MEM stage
//   Bus_rdata   out 32   read data (combinational)
//   Bus_wen     in   1   write strobe
//   Bus_wdata   in  32   write data
//   dram_addr   out 14   data RAM word address (Bus_addr[15:2])
//   dram_rdata  in  32   data RAM asynchronous read data
//   dram_wen    out  1   data RAM write enable
//   dram_wdata  out 32   data RAM write data (Bus_wdata)
//   sw          in  24   raw switches (asynchronous)
//   btn         in   5   raw buttons (asynchronous)
//   led         out 24   LED drive, active-high
//   dig_en      out  8   digit enables, active-low
//   dig_seg     out  8   segments {dp,g,f,e,d,c,b,a}, active-low
module io_bridge #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    output logic [31:0] Bus_rdata,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [13:0] dram_addr,
    input  logic [31:0] dram_rdata,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned      CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // Word offsets (Bus_addr[11:2]) of the byte offsets 0x000/0x020/0x060/0x070/0x078
    localparam logic [9:0] OFF_DISP  = 10'h000;
    localparam logic [9:0] OFF_TIMER = 10'h008;
    localparam logic [9:0] OFF_LED   = 10'h018;
    localparam logic [9:0] OFF_SW    = 10'h01C;
    localparam logic [9:0] OFF_BTN   = 10'h01E;

    logic [31:0]      r_disp;
    logic [23:0]      r_led;
    logic [23:0]      r_sw_meta, r_sw_sync;
    logic [4:0]       r_btn_meta, r_btn_sync;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [2:0]       r_digit_idx;
`ifdef IO_TIMER_EN
    logic [31:0]      r_timer;
`endif

    logic        w_io_hit;
    logic [9:0]  w_off;
    logic        w_wr_io;
    logic [31:0] w_io_word;
    logic [3:0]  w_nib;
    logic [7:0]  w_seg;
    logic        w_unused;

    assign w_io_hit = (Bus_addr[31:12] == 20'hFFFFF);
    assign w_off    = Bus_addr[11:2];
    assign w_wr_io  = Bus_wen & w_io_hit;
    // Byte lane bits play no part in decoding
    assign w_unused = &{1'b0, Bus_addr[1:0]};

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;
    assign dram_wen   = Bus_wen & ~w_io_hit;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_disp      <= '0;
            r_led       <= '0;
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_btn_meta  <= '0;
            r_btn_sync  <= '0;
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
`ifdef IO_TIMER_EN
            r_timer     <= '0;
`endif
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;

            // Scanner runs freely; DISP writes never disturb it
            if (r_scan_cnt == CNT_MAX) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            if (w_wr_io && w_off == OFF_DISP) r_disp <= Bus_wdata;
            if (w_wr_io && w_off == OFF_LED)  r_led  <= Bus_wdata[23:0];
`ifdef IO_TIMER_EN
            // A bus write takes priority over the increment
            if (w_wr_io && w_off == OFF_TIMER) r_timer <= Bus_wdata;
            else                               r_timer <= r_timer + 32'd1;
`endif
        end
    end

    always_comb begin
        w_io_word = '0;
        case (w_off)
            OFF_DISP:  w_io_word = r_disp;
`ifdef IO_TIMER_EN
            OFF_TIMER: w_io_word = r_timer;
`else
            OFF_TIMER: w_io_word = '0;
`endif
            OFF_LED:   w_io_word = {8'h00, r_led};
            OFF_SW:    w_io_word = {8'h00, r_sw_sync};
            OFF_BTN:   w_io_word = {27'h0, r_btn_sync};
            default:   w_io_word = '0;
        endcase
    end

    assign Bus_rdata = w_io_hit ? w_io_word : dram_rdata;

    assign w_nib = r_disp[{r_digit_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = 8'hFF;
        case (w_nib)
            4'h0: w_seg = 8'hC0;
            4'h1: w_seg = 8'hF9;
            4'h2: w_seg = 8'hA4;
            4'h3: w_seg = 8'hB0;
            4'h4: w_seg = 8'h99;
            4'h5: w_seg = 8'h92;
            4'h6: w_seg = 8'h82;
            4'h7: w_seg = 8'hF8;
            4'h8: w_seg = 8'h80;
            4'h9: w_seg = 8'h90;
            4'hA: w_seg = 8'h88;
            4'hB: w_seg = 8'h83;
            4'hC: w_seg = 8'hC6;
            4'hD: w_seg = 8'hA1;
            4'hE: w_seg = 8'h86;
            4'hF: w_seg = 8'h8E;
            default: w_seg = 8'hFF;
        endcase
    end

    assign led     = r_led;
    assign dig_en  = ~(8'b1 << r_digit_idx);
    assign dig_seg = w_seg;

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, rdata, wdata, drd, dwdata;
    logic        wen, dwen;
    logic [13:0] daddr;
    logic [23:0] sw, led;
    logic [4:0]  btn;
    logic [7:0]  en, seg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    io_bridge #(.SCAN_DIV(4)) dut (
        .cpu_clk(clk), .cpu_rst(rst),
        .Bus_addr(addr), .Bus_rdata(rdata), .Bus_wen(wen), .Bus_wdata(wdata),
        .dram_addr(daddr), .dram_rdata(drd), .dram_wen(dwen), .dram_wdata(dwdata),
        .sw(sw), .btn(btn), .led(led), .dig_en(en), .dig_seg(seg)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] drd;
        logic [31:0] exp_rd;
        logic        exp_dwen;
        logic [13:0] exp_daddr;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        dwen;
        logic [13:0] daddr;
        logic [31:0] dwdata;
    } bus_exp_t;

    typedef struct {
        logic [7:0] en;
        logic [7:0] seg;
    } scan_exp_t;

    vec_t      vecs [15];
    bus_exp_t  bus_q [$];
    scan_exp_t scan_q [$];
    logic [31:0] rd_q [$];
    logic [7:0]  seg_lut [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the drive point of the next cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample point inside the current cycle, well clear of the next edge
    task automatic settle();
        #3;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [31:0] r, input logic [31:0] er,
                                input logic edw, input logic [13:0] eda);
        vec_t v;
        v.addr = a; v.wen = w; v.wdata = d; v.drd = r;
        v.exp_rd = er; v.exp_dwen = edw; v.exp_daddr = eda;
        return v;
    endfunction

    // Drive a plain read, queue the expected word, compare it at the sample point
    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        addr = a; wen = 1'b0; wdata = '0;
        rd_q.push_back(exp);
        settle();
        e = rd_q.pop_front();
        chk(name, rdata, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_exp_t  be;
        scan_exp_t se;
        int        idx;
        logic [31:0] tmr_exp [3];

        vecs[0]  = mk(32'hFFFFF060, 1'b0, 32'h0,        32'h0,    32'h0,        1'b0, 14'h3C18);
        vecs[1]  = mk(32'hFFFFF060, 1'b1, 32'hAB123456, 32'h0,    32'h0,        1'b0, 14'h3C18);
        vecs[2]  = mk(32'hFFFFF060, 1'b0, 32'h0,        32'h0,    32'h00123456, 1'b0, 14'h3C18);
        vecs[3]  = mk(32'h00000010, 1'b1, 32'hDEADBEEF, 32'hCAFE, 32'hCAFE,     1'b1, 14'h0004);
        vecs[4]  = mk(32'h00000010, 1'b0, 32'h0,        32'h55,   32'h55,       1'b0, 14'h0004);
        vecs[5]  = mk(32'hFFFFF063, 1'b0, 32'h0,        32'h0,    32'h00123456, 1'b0, 14'h3C18);
        vecs[6]  = mk(32'hFFFFF100, 1'b0, 32'h0,        32'h99,   32'h0,        1'b0, 14'h3C40);
        vecs[7]  = mk(32'hFFFFF100, 1'b1, 32'h1234,     32'h0,    32'h0,        1'b0, 14'h3C40);
        vecs[8]  = mk(32'hFFFFF070, 1'b0, 32'h0,        32'h0,    32'h0,        1'b0, 14'h3C1C);
        vecs[9]  = mk(32'hFFFFF070, 1'b1, 32'hFFFFFFFF, 32'h0,    32'h0,        1'b0, 14'h3C1C);
        vecs[10] = mk(32'hFFFFF070, 1'b0, 32'h0,        32'h0,    32'h0,        1'b0, 14'h3C1C);
        vecs[11] = mk(32'hFFFEF060, 1'b1, 32'h11111111, 32'h77,   32'h77,       1'b1, 14'h3C18);
        vecs[12] = mk(32'hFFFFF060, 1'b0, 32'h0,        32'h0,    32'h00123456, 1'b0, 14'h3C18);
        vecs[13] = mk(32'hFFFFF000, 1'b1, 32'h76543210, 32'h0,    32'h0,        1'b0, 14'h3C00);
        vecs[14] = mk(32'hFFFFF000, 1'b0, 32'h0,        32'h0,    32'h76543210, 1'b0, 14'h3C00);

        // Reset cycle with a DRAM write: dram_wen is not gated by reset
        rst = 1'b1; addr = 32'h20; wen = 1'b1; wdata = 32'h1; drd = '0; sw = '0; btn = '0;
        #2;
        chk("dram_wen_during_reset", {31'h0, dwen}, 32'h1);
        step();
        rst = 1'b0; wen = 1'b0; addr = 32'hFFFFF060;
        settle();
        chk("reset_led",     {8'h0, led}, 32'h0);
        chk("reset_dig_en",  {24'h0, en}, 32'hFE);
        chk("reset_dig_seg", {24'h0, seg}, 32'hC0);
        step();

        for (int i = 0; i < 15; i++) begin
            addr = vecs[i].addr; wen = vecs[i].wen; wdata = vecs[i].wdata; drd = vecs[i].drd;
            be.rd = vecs[i].exp_rd; be.dwen = vecs[i].exp_dwen;
            be.daddr = vecs[i].exp_daddr; be.dwdata = vecs[i].wdata;
            bus_q.push_back(be);
            settle();
            be = bus_q.pop_front();
            chk($sformatf("vec%0d_rdata", i), rdata, be.rd);
            chk($sformatf("vec%0d_dram_wen", i), {31'h0, dwen}, {31'h0, be.dwen});
            chk($sformatf("vec%0d_dram_addr", i), {18'h0, daddr}, {18'h0, be.daddr});
            chk($sformatf("vec%0d_dram_wdata", i), dwdata, be.dwdata);
            step();
        end
        drd = '0;
        settle();
        chk("led_after_write", {8'h0, led}, 32'h00123456);
        step();

        // Switch synchronizer: two edges of latency
        sw = 24'hA5A5A5;
        read_chk("sw_edge0", 32'hFFFFF070, 32'h0); step();
        read_chk("sw_edge1", 32'hFFFFF070, 32'h0); step();
        read_chk("sw_edge2", 32'hFFFFF070, 32'h00A5A5A5); step();

        btn = 5'h15;
        read_chk("btn_edge0", 32'hFFFFF078, 32'h0); step();
        read_chk("btn_edge1", 32'hFFFFF078, 32'h0); step();
        read_chk("btn_edge2", 32'hFFFFF078, 32'h15); step();

        // Timer load then free-run across the wrap
`ifdef IO_TIMER_EN
        tmr_exp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
`else
        tmr_exp = '{32'h0, 32'h0, 32'h0};
`endif
        addr = 32'hFFFFF020; wen = 1'b1; wdata = 32'hFFFFFFFE;
        step();
        for (int i = 0; i < 3; i++) begin
            read_chk($sformatf("timer_rd%0d", i), 32'hFFFFF020, tmr_exp[i]);
            step();
        end

        // Reset mid-operation with a concurrent LED write: the write is dropped
        rst = 1'b1; addr = 32'hFFFFF060; wen = 1'b1; wdata = 32'hFFFFFFFF;
        settle();
        chk("io_write_dram_wen_rst", {31'h0, dwen}, 32'h0);
        step();
        rst = 1'b0;

        // Scanner: the cycle right after reset is scan count 0 of digit 0
        for (int k = 0; k < 36; k++) begin
            if (k == 0) begin
                addr = 32'hFFFFF000; wen = 1'b1; wdata = 32'h76543210;
            end else begin
                addr = 32'hFFFFF000; wen = 1'b0; wdata = '0;
            end
            idx = (k / 4) % 8;
            se.en  = ~(8'h01 << idx);
            se.seg = seg_lut[idx];
            scan_q.push_back(se);
            settle();
            if (k == 0) begin
                chk("midrst_led",  {8'h0, led}, 32'h0);
                chk("midrst_disp", rdata, 32'h0);
            end
            if (k == 1) chk("disp_readback", rdata, 32'h76543210);
            se = scan_q.pop_front();
            chk($sformatf("scan%0d_dig_en", k),  {24'h0, en},  {24'h0, se.en});
            chk($sformatf("scan%0d_dig_seg", k), {24'h0, seg}, {24'h0, se.seg});
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
